// File: rtl/vga_pkg.sv
// Shared timing defaults, counter width, FSM encoding and the registered
// control-output bundle for the 640x480@60 VGA sync generator.
package vga_pkg;

  localparam int unsigned CNT_W = 10;

  localparam int unsigned H_VISIBLE_DEF = 640;
  localparam int unsigned H_FP_DEF      = 16;
  localparam int unsigned H_SYNC_DEF    = 96;
  localparam int unsigned H_BP_DEF      = 48;
  localparam int unsigned V_VISIBLE_DEF = 480;
  localparam int unsigned V_FP_DEF      = 10;
  localparam int unsigned V_SYNC_DEF    = 2;
  localparam int unsigned V_BP_DEF      = 33;

  localparam int unsigned H_TOTAL_DEF      = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int unsigned V_TOTAL_DEF      = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int unsigned H_SYNC_START_DEF = H_VISIBLE_DEF + H_FP_DEF;
  localparam int unsigned H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF - 1;
  localparam int unsigned V_SYNC_START_DEF = V_VISIBLE_DEF + V_FP_DEF;
  localparam int unsigned V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF - 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } vga_state_e;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic video_on;
    logic line_start;
    logic frame_start;
  } vga_ctl_t;

  // Inclusive range test of a counter value against elaboration constants.
  function automatic logic in_range(input logic [CNT_W-1:0] x,
                                    input int unsigned      lo,
                                    input int unsigned      hi);
    return (x >= CNT_W'(lo)) && (x <= CNT_W'(hi));
  endfunction

endpackage

// File: rtl/sync_axis_counter.sv
// One raster axis: counts 0..TOTAL-1 on en, flags the wrap cycle and
// exposes the next count so the top can register outputs for the new position.
module sync_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned TOTAL = H_TOTAL_DEF
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_nxt_c,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Compare against LAST so the count never reaches the 10-bit overflow.
  always_comb begin
    wrap    = en && (count_q == LAST);
    count_d = count_q;
    if (wrap) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count       = count_q;
  assign count_nxt_c = count_d;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing in the fast clock domain, stepped by the pixel strobe.
// Sync, video_on and strobes are registered alongside hc/vc with zero skew.
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE   = H_VISIBLE_DEF,
  parameter int unsigned H_FP        = H_FP_DEF,
  parameter int unsigned H_SYNC      = H_SYNC_DEF,
  parameter int unsigned H_BP        = H_BP_DEF,
  parameter int unsigned V_VISIBLE   = V_VISIBLE_DEF,
  parameter int unsigned V_FP        = V_FP_DEF,
  parameter int unsigned V_SYNC      = V_SYNC_DEF,
  parameter int unsigned V_BP        = V_BP_DEF,
  parameter bit          SYNC_ACTIVE = 1'b0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             pix_en,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] hc,
  output logic [CNT_W-1:0] vc,
  output logic             line_start,
  output logic             frame_start
);

  localparam int unsigned H_TOTAL      = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL      = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_SYNC_START = H_VISIBLE + H_FP;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int unsigned V_SYNC_START = V_VISIBLE + V_FP;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  localparam vga_ctl_t CTL_RST = '{
    hsync:       ~SYNC_ACTIVE,
    vsync:       ~SYNC_ACTIVE,
    video_on:    1'b0,
    line_start:  1'b0,
    frame_start: 1'b0
  };

  vga_state_e       state_q;
  vga_state_e       state_d;
  vga_ctl_t         ctl_q;
  vga_ctl_t         ctl_d;
  logic             h_en;
  logic             h_wrap;
  logic             v_wrap;
  logic [CNT_W-1:0] hc_nxt;
  logic [CNT_W-1:0] vc_nxt;

  // Full output decode for a given (new) raster position.
  function automatic vga_ctl_t decode(input logic [CNT_W-1:0] h,
                                      input logic [CNT_W-1:0] v,
                                      input logic             ls,
                                      input logic             fs);
    vga_ctl_t c;
    c.hsync       = in_range(h, H_SYNC_START, H_SYNC_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    c.vsync       = in_range(v, V_SYNC_START, V_SYNC_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    c.video_on    = (h < CNT_W'(H_VISIBLE)) && (v < CNT_W'(V_VISIBLE));
    c.line_start  = ls;
    c.frame_start = fs;
    return c;
  endfunction

  assign h_en = pix_en && (state_q == ST_RUN);

  sync_axis_counter #(.TOTAL(H_TOTAL)) u_hcnt (
    .clk         (clk),
    .clr         (clr),
    .en          (h_en),
    .count       (hc),
    .count_nxt_c (hc_nxt),
    .wrap        (h_wrap)
  );

  sync_axis_counter #(.TOTAL(V_TOTAL)) u_vcnt (
    .clk         (clk),
    .clr         (clr),
    .en          (h_wrap),
    .count       (vc),
    .count_nxt_c (vc_nxt),
    .wrap        (v_wrap)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (pix_en) state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
  end

  // First strobe out of IDLE presents (0,0) without moving the counters.
  always_comb begin
    ctl_d             = ctl_q;
    ctl_d.line_start  = 1'b0;
    ctl_d.frame_start = 1'b0;
    case (state_q)
      ST_IDLE: if (pix_en) ctl_d = decode('0, '0, 1'b1, 1'b1);
      ST_RUN:  if (pix_en) ctl_d = decode(hc_nxt, vc_nxt, h_wrap, v_wrap);
      default: ctl_d = CTL_RST;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ctl_q <= CTL_RST;
    end else begin
      ctl_q <= ctl_d;
    end
  end

  assign hsync       = ctl_q.hsync;
  assign vsync       = ctl_q.vsync;
  assign video_on    = ctl_q.video_on;
  assign line_start  = ctl_q.line_start;
  assign frame_start = ctl_q.frame_start;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen with a shortened vertical raster (9 lines)
// so whole frames fit in a short run; horizontal timing is the real 800.
module tb_vga_sync_gen;

  localparam int unsigned VV = 4;
  localparam int unsigned VF = 1;
  localparam int unsigned VS = 2;
  localparam int unsigned VB = 2;
  localparam logic [31:0] RST_VEC = 32'h0180_0000;

  logic       clk;
  logic       clr;
  logic       pix_en;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic [9:0] hc;
  logic [9:0] vc;
  logic       line_start;
  logic       frame_start;

  int checks;
  int errors;
  bit m_run;
  int m_hc;
  int m_vc;
  bit m_ls;
  bit m_fs;
  int strobe_cnt;
  int fs_period;
  int cyc;
  int nls;
  int last_ls;
  int ls_gap;

  vga_sync_gen #(
    .V_VISIBLE (VV),
    .V_FP      (VF),
    .V_SYNC    (VS),
    .V_BP      (VB)
  ) dut (
    .clk         (clk),
    .clr         (clr),
    .pix_en      (pix_en),
    .hsync       (hsync),
    .vsync       (vsync),
    .video_on    (video_on),
    .hc          (hc),
    .vc          (vc),
    .line_start  (line_start),
    .frame_start (frame_start)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic finish_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  function automatic logic [31:0] obs_vec();
    return {7'd0, hsync, vsync, video_on, line_start, frame_start, hc, vc};
  endfunction

  // Expected outputs: hsync low 656..751, vsync low on lines 5..6, visible 640x4.
  function automatic logic [31:0] exp_vec();
    logic hs;
    logic vs;
    logic von;
    if (!m_run) begin
      hs  = 1'b1;
      vs  = 1'b1;
      von = 1'b0;
    end else begin
      hs  = !(m_hc >= 656 && m_hc <= 751);
      vs  = !(m_vc >= 5 && m_vc <= 6);
      von = (m_hc < 640) && (m_vc < 4);
    end
    return {7'd0, hs, vs, von, m_ls, m_fs, 10'(m_hc), 10'(m_vc)};
  endfunction

  task automatic model_reset();
    m_run = 1'b0;
    m_hc  = 0;
    m_vc  = 0;
    m_ls  = 1'b0;
    m_fs  = 1'b0;
  endtask

  task automatic tick(input bit pe);
    pix_en = pe;
    @(posedge clk);
    #1;
    if (!m_run) begin
      m_run = pe;
      m_ls  = pe;
      m_fs  = pe;
    end else if (pe) begin
      if (m_hc == 799) begin
        m_hc = 0;
        m_vc = (m_vc == 8) ? 0 : m_vc + 1;
      end else begin
        m_hc = m_hc + 1;
      end
      m_ls = (m_hc == 0);
      m_fs = (m_hc == 0) && (m_vc == 0);
    end else begin
      m_ls = 1'b0;
      m_fs = 1'b0;
    end
    if (pe) strobe_cnt++;
    if (frame_start) begin
      fs_period  = strobe_cnt;
      strobe_cnt = 0;
    end
    check("cyc", obs_vec(), exp_vec());
    if (errors >= 40) finish_run();
  endtask

  task automatic strobe(input int gap);
    repeat (gap) tick(1'b0);
    tick(1'b1);
  endtask

  task automatic run_to(input int h, input int v, input int gap);
    int n;
    n = 0;
    while (!(m_hc == h && m_vc == v) && n < 20000) begin
      strobe(gap);
      n++;
    end
    if (n >= 20000) check("timeout", {12'd0, hc, vc}, {12'd0, 10'(h), 10'(v)});
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    strobe_cnt = 0;
    fs_period  = 0;
    clr        = 1'b1;
    pix_en     = 1'b0;
    model_reset();

    // Reset with pix_en active is ignored.
    repeat (2) @(posedge clk);
    pix_en = 1'b1;
    @(posedge clk);
    #1;
    check("rst_vec", obs_vec(), RST_VEC);
    clr    = 1'b0;
    pix_en = 1'b0;

    // Start-up.
    repeat (3) tick(1'b0);
    check("pre_von", 32'(video_on), 32'd0);
    check("pre_hs", 32'(hsync), 32'd1);
    check("pre_vs", 32'(vsync), 32'd1);
    tick(1'b1);
    check("s0_fs", 32'(frame_start), 32'd1);
    check("s0_ls", 32'(line_start), 32'd1);
    check("s0_pos", {12'd0, hc, vc}, 32'd0);
    check("s0_von", 32'(video_on), 32'd1);
    tick(1'b0);
    check("s0_fs_w", 32'(frame_start), 32'd0);
    strobe(2);
    check("s1_hc", 32'(hc), 32'd1);
    check("s1_ls", 32'(line_start), 32'd0);

    // Horizontal boundaries at 1-in-4 strobes.
    run_to(639, 0, 3);
    check("h639_von", 32'(video_on), 32'd1);
    strobe(3);
    check("h640_von", 32'(video_on), 32'd0);
    run_to(655, 0, 3);
    check("h655_hs", 32'(hsync), 32'd1);
    strobe(3);
    check("h656_hs", 32'(hsync), 32'd0);
    run_to(751, 0, 3);
    check("h751_hs", 32'(hsync), 32'd0);
    strobe(3);
    check("h752_hs", 32'(hsync), 32'd1);
    run_to(799, 0, 3);
    strobe(3);
    check("wrap_pos", {12'd0, hc, vc}, {12'd0, 10'd0, 10'd1});
    check("wrap_ls", 32'(line_start), 32'd1);
    check("wrap_fs", 32'(frame_start), 32'd0);
    tick(1'b0);
    check("wrap_ls_w", 32'(line_start), 32'd0);

    // Vertical boundaries.
    run_to(0, 3, 3);
    check("v3_von", 32'(video_on), 32'd1);
    run_to(0, 4, 3);
    check("v4_von", 32'(video_on), 32'd0);
    check("v4_vs", 32'(vsync), 32'd1);
    run_to(0, 5, 3);
    check("v5_vs", 32'(vsync), 32'd0);
    run_to(799, 6, 3);
    check("v6_vs", 32'(vsync), 32'd0);
    strobe(3);
    check("v7_vs", 32'(vsync), 32'd1);
    run_to(799, 8, 3);
    strobe(3);
    check("fr_pos", {12'd0, hc, vc}, 32'd0);
    check("fr_fs", 32'(frame_start), 32'd1);
    check("fr_ls", 32'(line_start), 32'd1);
    check("fr_period", 32'(fs_period), 32'd7200);

    // pix_en held high for one full frame.
    cyc     = 0;
    nls     = 0;
    last_ls = 0;
    ls_gap  = 0;
    do begin
      tick(1'b1);
      cyc++;
      if (line_start) begin
        nls++;
        ls_gap  = cyc - last_ls;
        last_ls = cyc;
      end
    end while (!frame_start && cyc < 8000);
    check("hi_cyc", 32'(cyc), 32'd7200);
    check("hi_nls", 32'(nls), 32'd9);
    check("hi_gap", 32'(ls_gap), 32'd800);
    check("hi_fper", 32'(fs_period), 32'd7200);

    // Irregular strobe gaps of 0..10 cycles.
    repeat (300) strobe(int'($urandom_range(0, 10)));
    check("irr_pos", {12'd0, hc, vc}, {12'd0, 10'd300, 10'd0});

    // Asynchronous reset between edges at (300,2).
    run_to(300, 2, 0);
    check("ar_pre", {12'd0, hc, vc}, {12'd0, 10'd300, 10'd2});
    #2;
    clr = 1'b1;
    #1;
    check("ar_vec", obs_vec(), RST_VEC);
    pix_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("ar_hold", obs_vec(), RST_VEC);
    clr    = 1'b0;
    pix_en = 1'b0;
    model_reset();
    repeat (3) tick(1'b0);
    check("ar_idle_hc", 32'(hc), 32'd0);
    tick(1'b1);
    check("ar_fs", 32'(frame_start), 32'd1);
    check("ar_ls", 32'(line_start), 32'd1);
    tick(1'b0);
    check("ar_fs_w", 32'(frame_start), 32'd0);

    finish_run();
  end

endmodule
